carfield_boot_sequencer: RTL and testbench

- Synthesizable boot/preload sequencer that runs the Carfield SoC bring-up flow as a single bus master.
- After reset and a fixed number of RTC edges, it selects a flow from boot mode and preload mode.
  - Optional preload: the security-island (Ibex) image, then the Ibex wakeup at 0xE000_0080.
  - Host (Cheshire) image preload and host wakeup.
  - Polling of the end-of-computation (EOC) scratch register, then reporting the exit code.
- Sits between the image-streaming front end and the SoC debug/system bus.

---
 rtl/carfield_boot_sequencer.sv | 129 ++++++++++++
 tb/tb_carfield_boot_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carfield_boot_sequencer.sv
// carfield_boot_sequencer: single bus-master bring-up flow (OT preload/wake, host preload/wake, EOC polling)
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   rtc_i                         RTC level; rising edges gate the start of the flow
//   boot_mode_i, preload_mode_i   flow selection, latched once the RTC wait completes
//   host_entry_i                  host entry address written at host wake
//   img_*                         image word stream (valid/ready handshake)
//   bus_*                         single-outstanding request/grant/response bus master
//   busy_o, done_o, exit_code_o, error_o   sequence status
module carfield_boot_sequencer #(
   parameter int unsigned             AddrWidth       = 32,
   parameter int unsigned             DataWidth       = 32,
   parameter int unsigned             RtcWaitEdges    = 4,
   parameter logic [DataWidth-1:0]    OtBootAddr      = DataWidth'(32'hE000_0080),
   parameter logic [AddrWidth-1:0]    OtWakeRegAddr   = AddrWidth'(32'h0300_0000),
   parameter logic [AddrWidth-1:0]    HostWakeRegAddr = AddrWidth'(32'h0300_0004),
   parameter logic [AddrWidth-1:0]    EocRegAddr      = AddrWidth'(32'h0300_0008),
   parameter int unsigned             PollInterval    = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rtc_i,
   input  logic [1:0]           boot_mode_i,
   input  logic [1:0]           preload_mode_i,
   input  logic [AddrWidth-1:0] host_entry_i,
   input  logic                 img_valid_i,
   output logic                 img_ready_o,
   input  logic                 img_sel_i,
   input  logic [AddrWidth-1:0] img_addr_i,
   input  logic [DataWidth-1:0] img_data_i,
   input  logic                 img_last_i,
   output logic                 bus_req_o,
   output logic                 bus_we_o,
   output logic [AddrWidth-1:0] bus_addr_o,
   output logic [DataWidth-1:0] bus_wdata_o,
   input  logic                 bus_gnt_i,
   input  logic                 bus_rvalid_i,
   input  logic [DataWidth-1:0] bus_rdata_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [DataWidth-1:0] exit_code_o,
   output logic                 error_o
);
   typedef enum logic [3:0] {S_IDLE, S_DISPATCH, S_OT_LOAD, S_OT_WAKE, S_HOST_LOAD, S_HOST_WAKE, S_POLL, S_DONE, S_ERROR} state_t;
   typedef enum logic [1:0] {PH_NONE, PH_REQ, PH_RSP} phase_t;
   localparam int unsigned CntMax = PollInterval > RtcWaitEdges ? PollInterval : RtcWaitEdges;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   state_t                 r_state, w_next;
   phase_t                 r_ph;
   logic                   r_rtc_q, r_we, r_last;
   logic [CntW-1:0]        r_cnt;
   logic [1:0]             r_boot, r_pre;
   logic [AddrWidth-1:0]   r_addr;
   logic [DataWidth-1:0]   r_wdata, r_exit;
   logic                   w_rtc_rise, w_start, w_load, w_free, w_sel_ok, w_accept, w_bad, w_issue, w_cmpl;
   assign w_rtc_rise = rtc_i & ~r_rtc_q;
   assign w_start    = r_state == S_IDLE && w_rtc_rise && r_cnt == CntW'(RtcWaitEdges - 1);
   assign w_load     = r_state inside {S_OT_LOAD, S_HOST_LOAD};
   assign w_free     = r_ph == PH_NONE;
   assign w_sel_ok   = img_sel_i == (r_state == S_HOST_LOAD);
   assign w_accept   = w_load && w_free && img_valid_i && w_sel_ok;
   assign w_bad      = w_load && w_free && img_valid_i && !w_sel_ok;
   // wake writes fire on state entry; EOC reads fire once the poll gap has drained
   assign w_issue    = w_free && (r_state inside {S_OT_WAKE, S_HOST_WAKE} || (r_state == S_POLL && r_cnt == '0));
   // response may coincide with the grant or follow it
   assign w_cmpl     = (r_ph == PH_REQ && bus_gnt_i && bus_rvalid_i) || (r_ph == PH_RSP && bus_rvalid_i);
   assign img_ready_o = w_accept;
   assign bus_req_o   = r_ph == PH_REQ;
   assign bus_we_o    = r_we;
   assign bus_addr_o  = r_addr;
   assign bus_wdata_o = r_wdata;
   assign busy_o      = !(r_state inside {S_IDLE, S_DONE, S_ERROR});
   assign done_o      = r_state == S_DONE;
   assign error_o     = r_state == S_ERROR;
   assign exit_code_o = r_exit;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      w_next = w_start ? S_DISPATCH : S_IDLE;
         S_DISPATCH:  w_next = (r_boot == 2'd1 || (r_boot == 2'd0 && r_pre == 2'd3)) ? S_ERROR :
                               r_boot[1] ? S_POLL : r_pre == 2'd0 ? S_OT_LOAD : S_HOST_LOAD;
         S_OT_LOAD:   w_next = w_bad ? S_ERROR : (w_cmpl && r_last) ? S_OT_WAKE : S_OT_LOAD;
         S_OT_WAKE:   w_next = w_cmpl ? S_HOST_LOAD : S_OT_WAKE;
         S_HOST_LOAD: w_next = w_bad ? S_ERROR : (w_cmpl && r_last) ? S_HOST_WAKE : S_HOST_LOAD;
         S_HOST_WAKE: w_next = w_cmpl ? S_POLL : S_HOST_WAKE;
         S_POLL:      w_next = (w_cmpl && bus_rdata_i[0]) ? S_DONE : S_POLL;
         default:     w_next = r_state;
      endcase
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rtc_q <= 1'b0;
         r_cnt   <= '0;
         r_boot  <= '0;
         r_pre   <= '0;
         r_ph    <= PH_NONE;
         r_we    <= 1'b0;
         r_last  <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_exit  <= '0;
      end else begin
         r_rtc_q <= rtc_i;
         // r_cnt counts RTC edges in IDLE and the idle gap between EOC reads in POLL
         if (r_state == S_IDLE && w_rtc_rise) r_cnt <= w_start ? '0 : r_cnt + 1'b1;
         else if (r_state == S_POLL && w_free && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
         else if (r_state == S_POLL && w_cmpl && !bus_rdata_i[0]) r_cnt <= CntW'(PollInterval);
         if (w_start) begin
            r_boot <= boot_mode_i;
            r_pre  <= preload_mode_i;
         end
         if (w_accept || w_issue) begin
            r_ph    <= PH_REQ;
            r_we    <= r_state != S_POLL;
            r_last  <= img_last_i;
            r_addr  <= w_accept ? img_addr_i : r_state == S_OT_WAKE ? OtWakeRegAddr :
                       r_state == S_HOST_WAKE ? HostWakeRegAddr : EocRegAddr;
            r_wdata <= w_accept ? img_data_i : r_state == S_OT_WAKE ? OtBootAddr :
                       r_state == S_HOST_WAKE ? DataWidth'(host_entry_i) : '0;
         end else if (r_ph == PH_REQ && bus_gnt_i) r_ph <= bus_rvalid_i ? PH_NONE : PH_RSP;
         else if (r_ph == PH_RSP && bus_rvalid_i) r_ph <= PH_NONE;
         if (r_state == S_POLL && w_cmpl && bus_rdata_i[0]) r_exit <= bus_rdata_i >> 1;
      end
   end
endmodule

// File: tb/tb_carfield_boot_sequencer.sv
// tb_carfield_boot_sequencer: randomized self-checking bench with a transaction-level flow model
module tb_carfield_boot_sequencer;
   logic        clk = 1'b0, rst = 1'b1, rtc = 1'b0;
   logic [1:0]  boot = '0, pre = '0;
   logic [31:0] host_entry = '0;
   logic        img_valid = 1'b0, img_sel = 1'b0, img_last = 1'b0, img_ready;
   logic [31:0] img_addr = '0, img_data = '0;
   logic        bus_req, bus_we, gnt = 1'b0, rvalid = 1'b0;
   logic [31:0] bus_addr, bus_wdata, rdata = '0;
   logic        busy, done, error;
   logic [31:0] exit_code;

   carfield_boot_sequencer dut (
      .clk_i(clk), .rst_i(rst), .rtc_i(rtc), .boot_mode_i(boot), .preload_mode_i(pre),
      .host_entry_i(host_entry), .img_valid_i(img_valid), .img_ready_o(img_ready),
      .img_sel_i(img_sel), .img_addr_i(img_addr), .img_data_i(img_data), .img_last_i(img_last),
      .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
      .bus_gnt_i(gnt), .bus_rvalid_i(rvalid), .bus_rdata_i(rdata),
      .busy_o(busy), .done_o(done), .exit_code_o(exit_code), .error_o(error)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic sel; logic [31:0] addr; logic [31:0] data; logic last;} word_t;
   typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} txn_t;

   word_t       img_q[$];
   txn_t        exp_q[$];
   logic [31:0] eoc_q[$];
   int          checks = 0, passes = 0;
   int          img_idx = 0, eoc_idx = 0, nreq = 0, first_hold = -1, edges = 0;
   logic        exp_done, exp_err;
   logic [31:0] exp_exit;

   task automatic check(input string n, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h, expected %0h", n, act, req);
   endtask

   // Expected bus traffic derived from the flow rules: image words in stream order,
   // the wake writes after each image, then EOC reads until one has bit 0 set.
   task automatic build_model(input logic [1:0] b, input logic [1:0] p, input logic [31:0] entry);
      int k = 0;
      exp_q.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      exp_exit = '0;
      if (b == 2'd1 || (b == 2'd0 && p == 2'd3)) begin
         exp_err = 1'b1;
         return;
      end
      if (b == 2'd0) begin
         for (int ph = (p == 2'd0) ? 0 : 1; ph < 2; ph++) begin
            bit fin = 0;
            while (!fin) begin
               if (k >= img_q.size()) return;
               if (img_q[k].sel != (ph == 1)) begin
                  exp_err = 1'b1;
                  return;
               end
               exp_q.push_back('{1'b1, img_q[k].addr, img_q[k].data});
               fin = img_q[k].last;
               k++;
            end
            if (ph == 0) exp_q.push_back('{1'b1, 32'h0300_0000, 32'hE000_0080});
            else exp_q.push_back('{1'b1, 32'h0300_0004, entry});
         end
      end
      foreach (eoc_q[i]) begin
         exp_q.push_back('{1'b0, 32'h0300_0008, 32'h0});
         if (eoc_q[i][0]) begin
            exp_done = 1'b1;
            exp_exit = eoc_q[i] >> 1;
            break;
         end
      end
   endtask

   // Bus slave, image source, RTC generator and per-cycle compare process.
   initial begin : agent
      bit   waitr, prev_req, hist, drv, acc, cur_we;
      int   gdelay, rdelay, hold, rph;
      txn_t prev, e;
      waitr = 0; prev_req = 0; hist = 0; drv = 0; acc = 0; cur_we = 0;
      gdelay = 0; rdelay = 0; hold = 0; rph = 0; prev = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            edges = 0; hist = 0; drv = 0; rtc = 1'b0; rph = 0; acc = 0; waitr = 0; prev_req = 0;
            gnt = 1'b0; rvalid = 1'b0; img_valid = 1'b0;
            continue;
         end
         if (drv && !hist) edges++;
         hist = drv;
         drv = (rph % 6) >= 3;
         rph++;
         rtc = drv;
         if (acc) img_idx++;
         img_valid = img_idx < img_q.size() && $urandom_range(0, 3) != 0;
         if (img_idx < img_q.size()) begin
            img_sel  = img_q[img_idx].sel;
            img_addr = img_q[img_idx].addr;
            img_data = img_q[img_idx].data;
            img_last = img_q[img_idx].last;
         end
         gnt = 1'b0;
         rvalid = 1'b0;
         rdata = $urandom;
         #1;
         acc = img_valid && img_ready;
         if (bus_req || waitr) check("ready_low_while_pending", img_ready, 0);
         if (edges < 4) check("prestart_quiet", {busy, bus_req, done, error}, 0);
         if (!busy) check("not_busy_quiet", {bus_req, img_ready}, 0);
         if (waitr) begin
            check("single_outstanding", bus_req, 0);
            rdelay--;
            if (rdelay <= 0) begin
               rvalid = 1'b1;
               waitr = 0;
               if (!cur_we) begin
                  rdata = eoc_idx < eoc_q.size() ? eoc_q[eoc_idx] : 32'h0;
                  eoc_idx++;
               end
            end
         end else if (bus_req) begin
            if (prev_req) begin
               check("req_stable_addr", {bus_we, bus_addr}, {prev.we, prev.addr});
               check("req_stable_wdata", bus_wdata, prev.data);
            end else begin
               hold = 0;
               gdelay = (nreq == 0 && first_hold >= 0) ? first_hold : $urandom_range(0, 3);
            end
            prev = '{bus_we, bus_addr, bus_wdata};
            hold++;
            if (gdelay == 0) begin
               gnt = 1'b1;
               nreq++;
               prev_req = 0;
               cur_we = bus_we;
               if (nreq == 1 && first_hold >= 0) check("gnt_hold_cycles", hold, first_hold + 1);
               if (exp_q.size() == 0) begin
                  checks++;
                  $display("FAIL unexpected_txn: got we %b addr %0h, expected no transaction", bus_we, bus_addr);
               end else begin
                  e = exp_q.pop_front();
                  check("txn_we", bus_we, e.we);
                  check("txn_addr", bus_addr, e.addr);
                  if (e.we) check("txn_wdata", bus_wdata, e.data);
               end
               rdelay = $urandom_range(0, 2);
               if (rdelay == 0) begin
                  rvalid = 1'b1;
                  if (!bus_we) begin
                     rdata = eoc_idx < eoc_q.size() ? eoc_q[eoc_idx] : 32'h0;
                     eoc_idx++;
                  end
               end else waitr = 1;
            end else begin
               gdelay--;
               prev_req = 1;
            end
         end else prev_req = 0;
      end
   end

   task automatic rst_on();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_ctl", {busy, done, error, img_ready, bus_req, bus_we}, 0);
      check("rst_bus", {bus_addr, bus_wdata}, 0);
      check("rst_exit", exit_code, 0);
   endtask

   task automatic go(input logic [1:0] b, input logic [1:0] p, input logic [31:0] entry, input int fh, input bit wait_end);
      int i;
      build_model(b, p, entry);
      img_idx = 0; eoc_idx = 0; nreq = 0; first_hold = fh;
      boot = b; pre = p; host_entry = entry;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      for (i = 0; i < 200 && edges < 4; i++) @(negedge clk);
      #2;
      if (edges < 4) begin
         checks++;
         $display("FAIL rtc_wait_timeout: got %0d edges, expected 4", edges);
      end
      boot = 2'($urandom_range(0, 3));
      pre  = 2'($urandom_range(0, 3));
      if (!wait_end) return;
      for (i = 0; i < 4000 && !(done || error); i++) @(negedge clk);
      #2;
      if (!(done || error)) begin
         checks++;
         $display("FAIL end_timeout: got busy %b, expected done or error", busy);
      end
      repeat (3) @(negedge clk);
      #2;
      check("end_done", done, exp_done);
      check("end_error", error, exp_err);
      check("end_exit", exit_code, exp_exit);
      check("end_busy", busy, 0);
      check("end_txns_left", exp_q.size(), 0);
   endtask

   initial begin
      int i;
      // full preload flow with a 5-cycle grant stall on the first write
      rst_on();
      img_q.delete();
      for (int k = 0; k < 3; k++) img_q.push_back('{1'b0, 32'h1000_0000 + 4 * k, $urandom, k == 2});
      for (int k = 0; k < 2; k++) img_q.push_back('{1'b1, 32'h8000_0000 + 4 * k, $urandom, k == 1});
      eoc_q = '{32'h0, 32'h0, 32'h1};
      build_model(2'd0, 2'd0, 32'h8000_1000);
      check("model_len_t1", exp_q.size(), 10);
      check("model_otwake_t1", exp_q[3], {1'b1, 32'h0300_0000, 32'hE000_0080});
      go(2'd0, 2'd0, 32'h8000_1000, 5, 1);
      check("t1_exit", exit_code, 0);
      check("t1_done", done, 1);
      // autonomous boot: straight to polling
      rst_on();
      img_q.delete();
      eoc_q = '{32'h7};
      build_model(2'd2, 2'd0, 32'h0);
      check("model_exit_t2", exp_exit, 3);
      go(2'd2, 2'd0, 32'h0, -1, 1);
      check("t2_exit", exit_code, 3);
      // unsupported modes
      rst_on();
      eoc_q.delete();
      go(2'd1, 2'd0, 32'h0, -1, 1);
      check("t3_error", error, 1);
      rst_on();
      go(2'd0, 2'd3, 32'h0, -1, 1);
      check("t3b_error", error, 1);
      // host-only preload
      rst_on();
      img_q = '{'{1'b1, 32'h8000_0040, 32'hCAFE_F00D, 1'b1}};
      eoc_q = '{32'h0, 32'h5};
      build_model(2'd0, 2'd1, 32'h8000_0040);
      check("model_len_t4", exp_q.size(), 4);
      go(2'd0, 2'd1, 32'h8000_0040, -1, 1);
      check("t4_exit", exit_code, 2);
      // host word in the OT stream
      rst_on();
      img_q = '{'{1'b0, 32'h1000_0000, 32'h1111, 1'b0}, '{1'b1, 32'h1000_0004, 32'h2222, 1'b1}};
      eoc_q.delete();
      go(2'd0, 2'd0, 32'h0, -1, 1);
      check("t5_error", error, 1);
      // reset during polling, then a clean restart
      rst_on();
      img_q.delete();
      eoc_q.delete();
      for (int k = 0; k < 40; k++) eoc_q.push_back(32'h0);
      go(2'd2, 2'd0, 32'h0, -1, 0);
      for (i = 0; i < 3000 && !(eoc_idx >= 2 && bus_req); i++) begin
         @(negedge clk);
         #2;
      end
      if (!(eoc_idx >= 2 && bus_req)) begin
         checks++;
         $display("FAIL poll_reach_timeout: got %0d reads, expected 2", eoc_idx);
      end
      rst_on();
      eoc_q = '{32'h7};
      go(2'd2, 2'd0, 32'h0, -1, 1);
      // randomized flows
      for (int it = 0; it < 15; it++) begin
         logic [1:0] b, p;
         int n;
         b = 2'($urandom_range(0, 3));
         p = 2'($urandom_range(0, 3));
         rst_on();
         img_q.delete();
         eoc_q.delete();
         if (b == 2'd0 && p == 2'd0) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) img_q.push_back('{1'b0, $urandom, $urandom, k == n - 1});
         end
         if (b == 2'd0) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) img_q.push_back('{1'b1, $urandom, $urandom, k == n - 1});
         end
         if (img_q.size() > 0 && $urandom_range(0, 5) == 0) begin
            n = $urandom_range(0, img_q.size() - 1);
            img_q[n].sel = ~img_q[n].sel;
         end
         n = $urandom_range(0, 2);
         for (int k = 0; k < n; k++) eoc_q.push_back($urandom & 32'hFFFF_FFFE);
         eoc_q.push_back($urandom | 32'h1);
         go(b, p, $urandom, $urandom_range(0, 3) == 0 ? $urandom_range(1, 6) : -1, 1);
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
